qkv_tile_reader: RTL and testbench

Tile read engine on port B of the Q/K/V buffer BRAM, downstream of the systolic-array write path. On a start pulse it fetches one tile (NUM_READS_PER_TILE rows of DATA_WIDTH bits) at strided addresses. It absorbs the BRAM read latency in a small credit-controlled output FIFO and streams the rows to the next compute stage over a valid/ready interface with a last-beat marker.

---
 rtl/qkv_tile_reader.sv | 219 +++++++++++++++++++++
 tb/tb_qkv_tile_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qkv_tile_reader.sv
// qkv_tile_reader
//   Reads one tile (NUM_READS_PER_TILE rows) from port B of the Q/K/V buffer
//   BRAM at strided addresses. The BRAM read latency is absorbed by a small
//   credit-controlled FIFO, and rows are streamed out over valid/ready with a
//   last-beat marker.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_read          one-cycle pulse, starts a tile read when idle
//   reset_tile_counter  clears the tile counter (honoured only when idle)
//   enb, addrb          BRAM port-B read strobe and address
//   doutb               BRAM port-B data, valid READ_LATENCY cycles after enb
//   m_valid/m_ready     output row handshake
//   m_data, m_last      output row and final-row marker (FIFO head)
//   busy, read_done     tile in progress / one-cycle completion pulse
//   tile_idx            tile counter, used as the next tile base address
module qkv_tile_reader #(
    parameter int unsigned DATA_WIDTH         = 256,
    parameter int unsigned ADDR_WIDTH         = 16,
    parameter int unsigned NUM_READS_PER_TILE = 16,
    parameter int unsigned ADDR_STRIDE        = 23,
    parameter int unsigned READ_LATENCY       = 1,
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_read,
    input  logic                  reset_tile_counter,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  read_done,
    output logic [ADDR_WIDTH-1:0] tile_idx
);

    localparam int unsigned RW = $clog2(NUM_READS_PER_TILE);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] STRIDE_A   = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] TILE_MAX   = ADDR_WIDTH'(ADDR_STRIDE - 1);
    localparam logic [RW-1:0]         LAST_ROW   = RW'(NUM_READS_PER_TILE - 1);
    localparam logic [PW-1:0]         PTR_MAX    = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]           DEPTH_C    = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                  state_q, state_d;
    logic [RW-1:0]           row_cnt_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;   // address of the next row to issue
    logic [ADDR_WIDTH-1:0]   last_addr_q;  // address of the last issued row
    logic [ADDR_WIDTH-1:0]   tile_idx_q;

    logic [READ_LATENCY-1:0] infl_vld_q;
    logic [READ_LATENCY-1:0] infl_last_q;

    logic [DATA_WIDTH:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           fifo_cnt_q;

    logic                    issue;
    logic                    row_last;
    logic                    credit_ok;
    logic [CW-1:0]           infl_cnt;
    logic                    fifo_wr;
    logic                    pop;
    logic                    last_pop;

    // ------------------------------------------------------------------
    // Credit check: reads in flight plus rows already buffered must leave
    // room, so every returning row is guaranteed a FIFO slot.
    // ------------------------------------------------------------------
    always_comb begin
        infl_cnt = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            infl_cnt = infl_cnt + CW'(infl_vld_q[i]);
        end
    end

    assign credit_ok = ((CW + 1)'(infl_cnt) + (CW + 1)'(fifo_cnt_q)) < DEPTH_C;
    assign row_last  = (row_cnt_q == LAST_ROW);

    assign fifo_wr   = infl_vld_q[READ_LATENCY-1];
    assign m_valid   = (fifo_cnt_q != '0);
    assign m_data    = fifo_mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign m_last    = fifo_mem_q[rd_ptr_q][DATA_WIDTH];
    assign pop       = m_valid && m_ready;
    assign last_pop  = pop && m_last;

    assign enb       = issue;
    assign addrb     = issue ? cur_addr_q : last_addr_q;
    assign tile_idx  = tile_idx_q;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_read)          state_d = ISSUE;
            ISSUE: if (issue && row_last)   state_d = DRAIN;
            DRAIN: if (last_pop)            state_d = DONE;
            DONE:                           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        read_done = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            ISSUE: begin
                busy  = 1'b1;
                issue = credit_ok;
            end
            DRAIN:   busy      = 1'b1;
            DONE:    read_done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation and tile counter. The strided address is kept as
    // a running sum, so no multiplier is needed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q   <= '0;
            cur_addr_q  <= '0;
            last_addr_q <= '0;
            tile_idx_q  <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (start_read) begin
                    row_cnt_q  <= '0;
                    cur_addr_q <= reset_tile_counter ? '0 : tile_idx_q;
                    if (reset_tile_counter) begin
                        tile_idx_q <= '0;
                    end
                end else if (reset_tile_counter) begin
                    tile_idx_q <= '0;
                end
            end
            if (issue) begin
                last_addr_q <= cur_addr_q;
                cur_addr_q  <= cur_addr_q + STRIDE_A;
                row_cnt_q   <= row_cnt_q + RW'(1);
            end
            if ((state_q == DRAIN) && last_pop) begin
                tile_idx_q <= (tile_idx_q == TILE_MAX) ? '0 : tile_idx_q + ADDR_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight flags track each issued read until its data returns.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_vld_q  <= '0;
            infl_last_q <= '0;
        end else begin
            infl_vld_q[0]  <= issue;
            infl_last_q[0] <= issue && row_last;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                infl_vld_q[i]  <= infl_vld_q[i-1];
                infl_last_q[i] <= infl_last_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: {last, data} per entry. Storage is cleared on reset so
    // m_data/m_last come up as zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_wr) begin
                fifo_mem_q[wr_ptr_q] <= {infl_last_q[READ_LATENCY-1], doutb};
                wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
            end
            unique case ({fifo_wr, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    a_no_fifo_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(fifo_wr && !pop && (fifo_cnt_q == CW'(FIFO_DEPTH)))
    );

endmodule

// File: tb/tb_qkv_tile_reader.sv
// Bench for qkv_tile_reader: two instances (READ_LATENCY 1 and 2) share all
// control stimulus; each has its own BRAM model and reference model.
module tb_qkv_tile_reader;

    localparam int unsigned N      = 16;
    localparam int unsigned STRIDE = 23;

    logic clk = 1'b0;
    logic rst_n;
    logic start_read;
    logic reset_tile_counter;
    logic m_ready;

    logic [1:0]        enb, m_valid, m_last, busy, read_done;
    logic [1:0][15:0]  addrb, tile_idx;
    logic [1:0][255:0] m_data;
    logic [255:0]      doutb0, doutb1, pipe1;
    logic [255:0]      salt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qkv_tile_reader #(.READ_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .start_read(start_read),
        .reset_tile_counter(reset_tile_counter),
        .enb(enb[0]), .addrb(addrb[0]), .doutb(doutb0),
        .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
        .m_last(m_last[0]), .busy(busy[0]), .read_done(read_done[0]),
        .tile_idx(tile_idx[0])
    );

    qkv_tile_reader #(.READ_LATENCY(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .start_read(start_read),
        .reset_tile_counter(reset_tile_counter),
        .enb(enb[1]), .addrb(addrb[1]), .doutb(doutb1),
        .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
        .m_last(m_last[1]), .busy(busy[1]), .read_done(read_done[1]),
        .tile_idx(tile_idx[1])
    );

    function automatic logic [255:0] pat(input logic [15:0] a);
        return {16{a}} ^ salt;
    endfunction

    function automatic logic [15:0] row_addr(input int unsigned b, input int unsigned r);
        return 16'((b + r * STRIDE) % 65536);
    endfunction

    // BRAM models: valid data exactly READ_LATENCY cycles after enb, junk otherwise
    always @(posedge clk) begin
        doutb0 <= enb[0] ? pat(addrb[0]) : {8{$urandom}};
    end
    always @(posedge clk) begin
        pipe1  <= enb[1] ? pat(addrb[1]) : {8{$urandom}};
        doutb1 <= pipe1;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model, one per instance
    // ------------------------------------------------------------------
    bit           active    [2];
    bit           done_pend [2];
    bit           held_v    [2];
    logic [255:0] held_d    [2];
    logic         held_l    [2];
    int unsigned  base_m    [2];
    int unsigned  tile_m    [2];
    int unsigned  iss_cnt   [2];
    int unsigned  beat_cnt  [2];
    int           start_cyc [2];
    int           first_iss_rel  [2];
    int           first_beat_rel [2];
    int           last_beat_rel  [2];
    int           done_rel       [2];
    int           iss_before_pop [2];
    int unsigned  first_addr     [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk("rst_enb",   enb[k], 0);
                chk("rst_addrb", addrb[k], 0);
                chk("rst_valid", m_valid[k], 0);
                chk("rst_data",  m_data[k], 0);
                chk("rst_last",  m_last[k], 0);
                chk("rst_busy",  busy[k], 0);
                chk("rst_done",  read_done[k], 0);
                chk("rst_tile",  tile_idx[k], 0);
                active[k]    = 1'b0;
                done_pend[k] = 1'b0;
                held_v[k]    = 1'b0;
                tile_m[k]    = 0;
            end else begin
                bit last_hs;
                bit was_active;
                last_hs = 1'b0;
                chk("tile_idx", tile_idx[k], tile_m[k]);
                chk("busy", busy[k], active[k] && (cyc > start_cyc[k]) && !done_pend[k]);
                chk("read_done", read_done[k], done_pend[k]);
                if (read_done[k] && done_pend[k]) done_rel[k] = cyc - start_cyc[k];
                if (held_v[k]) begin
                    chk("hold_valid", m_valid[k], 1);
                    chk("hold_data", m_data[k], held_d[k]);
                    chk("hold_last", m_last[k], held_l[k]);
                end
                if (enb[k]) begin
                    if (!active[k] || iss_cnt[k] >= N) begin
                        chk("spurious_issue", enb[k], 0);
                    end else begin
                        chk("addrb", addrb[k], row_addr(base_m[k], iss_cnt[k]));
                        if (iss_cnt[k] == 0) begin
                            first_iss_rel[k] = cyc - start_cyc[k];
                            first_addr[k]    = addrb[k];
                        end
                        if (beat_cnt[k] == 0) iss_before_pop[k]++;
                        iss_cnt[k]++;
                    end
                end
                if (m_valid[k] && (!active[k] || beat_cnt[k] >= N)) begin
                    chk("spurious_valid", m_valid[k], 0);
                end else if (m_valid[k] && m_ready) begin
                    chk("m_data", m_data[k], pat(row_addr(base_m[k], beat_cnt[k])));
                    chk("m_last", m_last[k], beat_cnt[k] == N - 1);
                    if (beat_cnt[k] == 0) first_beat_rel[k] = cyc - start_cyc[k];
                    if (beat_cnt[k] == N - 1) begin
                        last_beat_rel[k] = cyc - start_cyc[k];
                        last_hs = 1'b1;
                    end
                    beat_cnt[k]++;
                end
                held_v[k] = m_valid[k] && !m_ready;
                held_d[k] = m_data[k];
                held_l[k] = m_last[k];

                was_active = active[k];
                if (done_pend[k]) begin
                    active[k]    = 1'b0;
                    done_pend[k] = 1'b0;
                end
                if (last_hs) begin
                    done_pend[k] = 1'b1;
                    tile_m[k]    = (tile_m[k] + 1) % STRIDE;
                end
                if (!was_active) begin
                    if (start_read) begin
                        active[k]         = 1'b1;
                        start_cyc[k]      = cyc;
                        base_m[k]         = reset_tile_counter ? 0 : tile_m[k];
                        if (reset_tile_counter) tile_m[k] = 0;
                        iss_cnt[k]        = 0;
                        beat_cnt[k]       = 0;
                        iss_before_pop[k] = 0;
                        first_iss_rel[k]  = -1;
                        first_beat_rel[k] = -1;
                        last_beat_rel[k]  = -1;
                        done_rel[k]       = -1;
                    end else if (reset_tile_counter) begin
                        tile_m[k] = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    //   mode 0: m_ready high   1: random m_ready   2: backpressure
    //   mode 3: stray controls at cycle 5   4: reset in cycles 8-9
    // ------------------------------------------------------------------
    task automatic run_tile(input int mode);
        int rel;
        int t;
        @(posedge clk); #1;
        start_read = 1'b1;
        rel = 0;
        t   = 0;
        case (mode)
            1:       m_ready = ($urandom_range(0, 3) != 0);
            2:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
        do begin
            @(posedge clk); #1;
            rel++;
            t++;
            start_read         = 1'b0;
            reset_tile_counter = 1'b0;
            case (mode)
                1: m_ready = ($urandom_range(0, 3) != 0);
                2: m_ready = (rel > 10) ? ((rel % 2) == 1) : 1'b0;
                3: begin
                    m_ready = 1'b1;
                    if (rel == 5) begin
                        start_read         = 1'b1;
                        reset_tile_counter = 1'b1;
                    end
                end
                4: begin
                    m_ready = 1'b1;
                    rst_n   = !(rel == 8 || rel == 9);
                end
                default: m_ready = 1'b1;
            endcase
        end while ((active[0] || active[1]) && t < 400);
        chk("idle_timeout", {active[1], active[0]}, 0);
        @(posedge clk); #1;
        rst_n              = 1'b1;
        start_read         = 1'b0;
        reset_tile_counter = 1'b0;
    endtask

    task automatic pulse_rtc();
        @(posedge clk); #1;
        reset_tile_counter = 1'b1;
        @(posedge clk); #1;
        reset_tile_counter = 1'b0;
        @(negedge clk);
        chk("rtc_clear_l1", tile_idx[0], 0);
        chk("rtc_clear_l2", tile_idx[1], 0);
    endtask

    initial begin
        salt               = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
        rst_n              = 1'b0;
        start_read         = 1'b0;
        reset_tile_counter = 1'b0;
        m_ready            = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // basic full-throughput tile, timing for both latencies
        run_tile(0);
        for (int k = 0; k < 2; k++) begin
            chk("first_issue_cyc", first_iss_rel[k], 1);
            chk("first_beat_cyc", first_beat_rel[k], k + 3);
            chk("last_beat_cyc", last_beat_rel[k], k + 2 + N);
            chk("read_done_cyc", done_rel[k], k + 3 + N);
        end

        // backpressure: credits limit issue to FIFO_DEPTH before first pop
        run_tile(2);
        chk("credit_issues_l1", iss_before_pop[0], 4);
        chk("credit_issues_l2", iss_before_pop[1], 4);

        // stray start/reset_tile_counter while busy
        run_tile(3);
        chk("beats_after_stray", beat_cnt[0], N);

        // counter wrap over 24 back-to-back tiles with random m_ready
        pulse_rtc();
        for (int i = 0; i < 24; i++) begin
            run_tile(1);
            chk("tile_base_l1", first_addr[0], i % STRIDE);
            chk("tile_base_l2", first_addr[1], i % STRIDE);
        end
        pulse_rtc();
        run_tile(0);
        chk("base_after_rtc", first_addr[0], 0);

        // mid-tile reset, then restart from base 0
        run_tile(4);
        repeat (5) @(posedge clk);
        run_tile(1);
        chk("base_after_reset_l1", first_addr[0], 0);
        chk("base_after_reset_l2", first_addr[1], 0);
        run_tile(1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
